// File: rtl/word64_fifo_ctrl_pkg.sv
// Shared constants and types for the word64 SRAM streaming FIFO controller.
package localbuf_pkg;

    localparam int DW     = 128;
    localparam int AW     = 6;
    localparam int DEPTH  = 64;
    localparam int LANES  = 8;
    localparam int LANE_W = DW / LANES;
    localparam int CW     = 7;

    typedef logic [DW-1:0]    line_t;
    typedef logic [LANES-1:0] lane_mask_t;
    typedef logic [AW-1:0]    addr_t;
    typedef logic [CW-1:0]    count_t;

    localparam lane_mask_t WE_IDLE  = 8'hFF;
    localparam count_t     FULL_CNT = count_t'(DEPTH);

endpackage

// File: rtl/word64_fifo_ctrl_skid2.sv
// Two-entry output buffer absorbing SRAM read data; entry 0 is always the head.
module word64_skid2
    import localbuf_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       push_i,
    input  line_t      push_data_i,
    input  logic       pop_i,
    output logic       valid_o,
    output line_t      head_o,
    output logic [1:0] used_o
);

    line_t      e0_q, e0_d;
    line_t      e1_q, e1_d;
    logic [1:0] used_q, used_d;
    logic       pop;

    assign valid_o = (used_q != 2'd0);
    assign head_o  = e0_q;
    assign used_o  = used_q;
    assign pop     = pop_i && valid_o;

    always_comb begin
        e0_d   = e0_q;
        e1_d   = e1_q;
        used_d = used_q;
        if (clear_i) begin
            e0_d   = '0;
            e1_d   = '0;
            used_d = 2'd0;
        end else begin
            unique case ({push_i, pop})
                2'b11: begin
                    // Occupancy is unchanged; the new line lands behind the surviving entry.
                    if (used_q == 2'd1) begin
                        e0_d = push_data_i;
                    end else begin
                        e0_d = e1_q;
                        e1_d = push_data_i;
                    end
                end
                2'b01: begin
                    e0_d   = e1_q;
                    used_d = used_q - 2'd1;
                end
                2'b10: begin
                    if (used_q == 2'd0) e0_d = push_data_i;
                    else                e1_d = push_data_i;
                    used_d = used_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e0_q   <= '0;
            e1_q   <= '0;
            used_q <= 2'd0;
        end else begin
            e0_q   <= e0_d;
            e1_q   <= e1_d;
            used_q <= used_d;
        end
    end

endmodule

// File: rtl/word64_fifo_ctrl.sv
// Streams lines through a 64x128b dual-port SRAM: port A writes, port B reads,
// with a two-entry skid hiding the one-cycle read latency.
module word64_fifo_ctrl
    import localbuf_pkg::*;
(
    input  logic       CK,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  line_t      wr_data,
    input  lane_mask_t wr_mask,
    output logic       rd_valid,
    input  logic       rd_ready,
    output line_t      rd_data,
    output count_t     level,
    output logic       full,
    output logic       empty,
    output addr_t      sram_A,
    output addr_t      sram_B,
    output logic       sram_OEA,
    output logic       sram_OEB,
    output lane_mask_t sram_WEAN,
    output lane_mask_t sram_WEBN,
    output line_t      sram_DIA,
    output line_t      sram_DIB,
    input  line_t      sram_DOB
);

    addr_t      wr_ptr_q, wr_ptr_d;
    addr_t      rd_ptr_q, rd_ptr_d;
    count_t     cnt_q, cnt_d;
    logic       inflight_q, inflight_d;
    logic [1:0] skid_used;
    logic [2:0] pending;
    logic       push;
    logic       rd_issue;

    // Every action is gated by rst_n so nothing reaches the SRAM while reset is low.
    assign full     = (cnt_q == FULL_CNT);
    assign wr_ready = rst_n && !full && !clear;
    assign push     = wr_valid && wr_ready;
    assign pending  = {1'b0, skid_used} + {2'b00, inflight_q};
    assign rd_issue = rst_n && (cnt_q != '0) && (pending < 3'd2) && !clear;

    assign sram_A    = wr_ptr_q;
    assign sram_B    = rd_ptr_q;
    assign sram_WEAN = push ? ~wr_mask : WE_IDLE;
    assign sram_DIA  = wr_data;
    assign sram_OEB  = rd_issue;
    assign sram_OEA  = 1'b0;
    assign sram_WEBN = WE_IDLE;
    assign sram_DIB  = '0;

    assign level = cnt_q + count_t'(inflight_q) + count_t'(skid_used);
    assign empty = (level == '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        inflight_d = rd_issue;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            inflight_d = 1'b0;
        end else begin
            if (push)     wr_ptr_d = wr_ptr_q + addr_t'(1);
            if (rd_issue) rd_ptr_d = rd_ptr_q + addr_t'(1);
            unique case ({push, rd_issue})
                2'b10:   cnt_d = cnt_q + count_t'(1);
                2'b01:   cnt_d = cnt_q - count_t'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // DOB is valid the cycle after issue; a clear in that cycle discards it.
    word64_skid2 u_skid (
        .clk_i       (CK),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .push_i      (inflight_q),
        .push_data_i (sram_DOB),
        .pop_i       (rd_ready),
        .valid_o     (rd_valid),
        .head_o      (rd_data),
        .used_o      (skid_used)
    );

`ifndef SYNTHESIS
    a_no_collision: assert property (@(posedge CK) disable iff (!rst_n)
        !((sram_WEAN != WE_IDLE) && sram_OEB && (sram_A == sram_B)));
`endif

endmodule

// File: tb/tb_word64_fifo_ctrl.sv
// Directed bench for word64_fifo_ctrl with a behavioural SRAM and a scoreboard monitor.
module tb_word64_fifo_ctrl;
    import localbuf_pkg::*;

    logic       CK = 1'b0;
    logic       rst_n, clear, wr_valid, rd_ready;
    line_t      wr_data, rd_data, sram_DIA, sram_DIB, sram_DOB;
    lane_mask_t wr_mask, sram_WEAN, sram_WEBN;
    logic       wr_ready, rd_valid, full, empty, sram_OEA, sram_OEB;
    count_t     level;
    addr_t      sram_A, sram_B;

    always #5 CK = ~CK;

    word64_fifo_ctrl dut (
        .CK(CK), .rst_n(rst_n), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level), .full(full), .empty(empty),
        .sram_A(sram_A), .sram_B(sram_B), .sram_OEA(sram_OEA), .sram_OEB(sram_OEB),
        .sram_WEAN(sram_WEAN), .sram_WEBN(sram_WEBN),
        .sram_DIA(sram_DIA), .sram_DIB(sram_DIB), .sram_DOB(sram_DOB)
    );

    // Behavioural SRAM: lane-masked write on A, registered read on B.
    line_t mem [DEPTH];
    always @(posedge CK) begin
        for (int l = 0; l < LANES; l++)
            if (!sram_WEAN[l]) mem[sram_A][l*LANE_W +: LANE_W] <= sram_DIA[l*LANE_W +: LANE_W];
        if (sram_OEB) sram_DOB <= mem[sram_B];
    end

    int    checks = 0;
    int    passed = 0;
    line_t exp_q[$];
    line_t shadow [DEPTH];
    int    wp = 0;
    int    max_level = 0;
    int    collisions = 0;
    bit    prod_done;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic line_t merge(input line_t old, input line_t d, input lane_mask_t m);
        line_t r = old;
        for (int l = 0; l < LANES; l++)
            if (m[l]) r[l*LANE_W +: LANE_W] = d[l*LANE_W +: LANE_W];
        return r;
    endfunction

    task automatic record_push(input line_t d, input lane_mask_t m);
        line_t e;
        e = merge(shadow[wp], d, m);
        shadow[wp] = e;
        wp = (wp + 1) % DEPTH;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_line(input line_t d, input lane_mask_t m);
        bit done = 0;
        wr_valid = 1'b1; wr_data = d; wr_mask = m;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge CK);
            if (wr_ready) begin
                record_push(d, m);
                done = 1;
            end
            @(posedge CK); #1;
        end
        wr_valid = 1'b0;
        if (!done) begin
            checks++;
            $display("FAIL push_timeout: line %0h not accepted, required acceptance within 2000 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CK);
        #1;
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        rd_ready = 1'b1;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge CK); #1;
            if (exp_q.size() == 0 && level == '0) done = 1;
        end
        checks++;
        if (done) passed++;
        else $display("FAIL %s_drain: level %0d queue %0d, required 0/0", name, level, exp_q.size());
        chk({name, "_empty"}, empty, 1'b1);
    endtask

    always @(negedge CK) begin
        if (rst_n) begin
            if (int'(level) > max_level) max_level = int'(level);
            if (sram_WEAN != WE_IDLE && sram_OEB && sram_A == sram_B) collisions++;
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_pop: got %0h, required no output", rd_data);
                end else begin
                    chk("pop_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; wr_valid = 1'b1; rd_ready = 1'b0;
        wr_data = 128'h5555; wr_mask = 8'hFF;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

        // Reset state, with a push offered to prove it is ignored.
        idle(3);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_level", level, '0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_wean", sram_WEAN, 8'hFF);
        chk("rst_oeb", sram_OEB, 1'b0);
        chk("rst_a", sram_A, '0);
        chk("rst_b", sram_B, '0);
        chk("const_oea", sram_OEA, 1'b0);
        chk("const_webn", sram_WEBN, 8'hFF);
        chk("const_dib", sram_DIB, '0);
        wr_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);

        // First push: port A drive, then latency to rd_valid.
        wr_valid = 1'b1; wr_data = 128'h01; wr_mask = 8'hFF;
        @(negedge CK);
        chk("push_wr_ready", wr_ready, 1'b1);
        chk("push_wean", sram_WEAN, 8'h00);
        chk("push_a", sram_A, 6'd0);
        chk("push_dia", sram_DIA, 128'h01);
        if (wr_ready) record_push(128'h01, 8'hFF);
        @(posedge CK); #1;
        wr_valid = 1'b0;
        @(negedge CK);
        chk("lat_t0_rd_valid", rd_valid, 1'b0);
        chk("lat_t0_oeb", sram_OEB, 1'b1);
        chk("lat_t0_b", sram_B, 6'd0);
        @(posedge CK); @(negedge CK);
        chk("lat_t1_rd_valid", rd_valid, 1'b0);
        chk("lat_t1_level", level, 7'd1);
        @(posedge CK); @(negedge CK);
        chk("lat_t2_rd_valid", rd_valid, 1'b1);
        chk("lat_t2_rd_data", rd_data, 128'h01);
        @(posedge CK); #1;
        rd_ready = 1'b1;
        push_line(128'h02, 8'hFF);
        push_line(128'h03, 8'hFF);
        wait_drain("three");

        // Fill: 64 in SRAM plus 2 in the skid, then a held 67th line.
        rd_ready = 1'b0;
        for (int i = 0; i < 66; i++) push_line({16{8'(i + 16)}}, 8'hFF);
        idle(3);
        chk("fill_level", level, 7'd66);
        chk("fill_full", full, 1'b1);
        chk("fill_wr_ready", wr_ready, 1'b0);
        chk("fill_rd_valid", rd_valid, 1'b1);
        wr_valid = 1'b1; wr_data = 128'hDEAD;
        @(negedge CK);
        chk("held_wean", sram_WEAN, 8'hFF);
        chk("held_wr_ready", wr_ready, 1'b0);
        @(posedge CK); #1;
        wr_valid = 1'b0;

        // Steady state from full: pop and push together, pointers wrap repeatedly.
        rd_ready = 1'b1;
        for (int i = 0; i < 200; i++) push_line({$urandom(), $urandom(), $urandom(), $urandom()}, 8'hFF);
        wait_drain("steady");

        // Partial-lane write over a fully written slot one lap earlier.
        push_line({8{16'h1111}}, 8'hFF);
        for (int i = 0; i < DEPTH - 1; i++) push_line({$urandom(), $urandom(), $urandom(), $urandom()}, 8'hFF);
        push_line({8{16'h2222}}, 8'h0F);
        wait_drain("mask");

        // Random valid/ready on both sides, random lane masks.
        prod_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 2500; n++) begin
                    if ($urandom_range(0, 1) == 1)
                        push_line({$urandom(), $urandom(), $urandom(), $urandom()},
                                  ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom()));
                    else
                        idle(1);
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    rd_ready = ($urandom_range(0, 1) == 1);
                    @(posedge CK); #1;
                end
            end
        join
        wait_drain("random");

        // Clear with a read in flight at level 10.
        rd_ready = 1'b0;
        for (int i = 0; i < 11; i++) push_line({16{8'(i + 128)}}, 8'hFF);
        idle(4);
        chk("pre_clear_level11", level, 7'd11);
        rd_ready = 1'b1;
        @(posedge CK); #1;
        rd_ready = 1'b0;
        idle(1);
        chk("clear_level10", level, 7'd10);
        clear = 1'b1; wr_valid = 1'b1; wr_data = 128'hBB; wr_mask = 8'hFF;
        @(negedge CK);
        chk("clear_wr_ready", wr_ready, 1'b0);
        chk("clear_wean", sram_WEAN, 8'hFF);
        chk("clear_oeb", sram_OEB, 1'b0);
        @(posedge CK); #1;
        clear = 1'b0; wr_valid = 1'b0;
        exp_q.delete();
        wp = 0;
        chk("post_clear_level", level, '0);
        chk("post_clear_rd_valid", rd_valid, 1'b0);
        chk("post_clear_a", sram_A, '0);
        chk("post_clear_b", sram_B, '0);
        idle(3);
        chk("post_clear_dropped", rd_valid, 1'b0);
        push_line(128'hAA, 8'hFF);
        wait_drain("after_clear");

        // Asynchronous reset in the middle of traffic.
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_line(128'h300 + 128'(i), 8'hFF);
        wr_valid = 1'b1; wr_data = 128'hCC;
        rst_n = 1'b0;
        #1;
        chk("midrst_wean", sram_WEAN, 8'hFF);
        chk("midrst_wr_ready", wr_ready, 1'b0);
        chk("midrst_level", level, '0);
        chk("midrst_rd_valid", rd_valid, 1'b0);
        idle(2);
        wr_valid = 1'b0;
        rst_n = 1'b1;
        exp_q.delete();
        wp = 0;
        idle(1);
        push_line(128'h77, 8'hFF);
        wait_drain("after_reset");

        chk("max_level", max_level, 66);
        chk("collisions", collisions, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
